// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder: one full-adder cell and a carry flop process the operands
// LSB first, one bit per clock. Operands arrive over a valid/ready handshake.
// The WIDTH-bit sum, the unsigned carry-out and the signed-overflow flag leave
// over a second valid/ready handshake. This is a small-area alternative to a
// ripple adder path.
//
// Ports:
//   clk_i        in   1      clock; all state updates on the rising edge
//   rst_i        in   1      synchronous active-high reset
//   in_valid_i   in   1      a_i/b_i/c_i valid
//   in_ready_o   out  1      block can accept operands (IDLE only)
//   a_i          in   WIDTH  operand A
//   b_i          in   WIDTH  operand B
//   c_i          in   1      carry-in
//   out_valid_o  out  1      result valid (DONE only)
//   out_ready_i  in   1      consumer accepts result
//   sum_o        out  WIDTH  low WIDTH bits of A+B+c_i
//   carry_o      out  1      carry out of the MSB
//   overflow_o   out  1      signed overflow (carry into MSB ^ carry out of MSB)
//
// Timing: operands accepted at edge T give out_valid_o after edge T+WIDTH.
// The minimum initiation interval is WIDTH+2 cycles.
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_cy;

    // Result registers are separate from the working shift registers so the
    // presented result stays put while the next operation is being computed.
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_ovf;

    logic             w_fa_sum;
    logic             w_fa_cy;
    logic             w_last;

    // The single full-adder cell.
    assign w_fa_sum = r_a_sh[0] ^ r_b_sh[0] ^ r_cy;
    assign w_fa_cy  = (r_a_sh[0] & r_b_sh[0]) |
                      (r_a_sh[0] & r_cy)      |
                      (r_b_sh[0] & r_cy);
    assign w_last   = (r_cnt == LAST_BIT);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (in_valid_i)  w_next_state = S_RUN;
            S_RUN:   if (w_last)      w_next_state = S_DONE;
            S_DONE:  if (out_ready_i) w_next_state = S_IDLE;
            default:                  w_next_state = S_IDLE;
        endcase
    end

    // Handshake outputs depend on state alone, never on the peer's signals.
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (r_state)
            S_IDLE:  in_ready_o  = 1'b1;
            S_DONE:  out_valid_o = 1'b1;
            default: ;
        endcase
    end

    // Serial datapath.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt    <= '0;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_cy     <= 1'b0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        r_a_sh <= a_i;
                        r_b_sh <= b_i;
                        r_cy   <= c_i;
                        r_cnt  <= '0;
                    end
                end
                S_RUN: begin
                    r_sum_sh <= {w_fa_sum, r_sum_sh[WIDTH-1:1]};
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_cy     <= w_fa_cy;
                    if (w_last) begin
                        // On the MSB step r_cy is the carry into the MSB.
                        r_sum   <= {w_fa_sum, r_sum_sh[WIDTH-1:1]};
                        r_carry <= w_fa_cy;
                        r_ovf   <= r_cy ^ w_fa_cy;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum_o      = r_sum;
    assign carry_o    = r_carry;
    assign overflow_o = r_ovf;

endmodule
